// File: rtl/call_stack_if.sv
// Control-unit <-> return-address-stack signal bundle.
// The control unit (master) drives CALL/RET requests; the stack (slave) reports top entry and status.
interface call_stack_if #(
  parameter int ADDR_W     = 8,
  parameter int DEPTH_LOG2 = 3
);
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic              clear_err;
  logic [ADDR_W-1:0] top_addr;
  logic [DEPTH_LOG2:0] sp;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, push_addr, clear_err,
    input  top_addr, sp, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_addr, clear_err,
    output top_addr, sp, empty, full, overflow, underflow
  );
endinterface

// File: rtl/call_stack.sv
// Hardware return-address stack: DEPTH program-counter entries, with a stack pointer and
// sticky overflow/underflow flags for the debug path.
module call_stack #(
  parameter int ADDR_W     = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  call_stack_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] SP_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [ADDR_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2:0]   sp_q;
  logic [DEPTH_LOG2:0]   sp_next;
  logic [DEPTH_LOG2:0]   sp_m1;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  do_write;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  is_empty;
  logic                  is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SP_FULL);
  assign sp_m1    = sp_q - 1'b1;

  // Decide this cycle's write, pointer move and error events from the push/pop request.
  // A simultaneous push+pop on a non-empty stack overwrites the top in place (tail call).
  always_comb begin
    do_write = 1'b0;
    wr_idx   = '0;
    sp_next  = sp_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          do_write = 1'b1;
          wr_idx   = sp_q[DEPTH_LOG2-1:0];
          sp_next  = sp_q + 1'b1;
        end
      end
      2'b01: begin
        if (is_empty) begin
          unf_set = 1'b1;
        end else begin
          sp_next = sp_m1;
        end
      end
      2'b11: begin
        do_write = 1'b1;
        if (is_empty) begin
          wr_idx  = '0;
          sp_next = (DEPTH_LOG2+1)'(1);
        end else begin
          wr_idx  = sp_m1[DEPTH_LOG2-1:0];
        end
      end
      default: ;
    endcase
  end

  // Storage is deliberately left unreset; holding it during reset also aborts any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_next;
      ovf_q <= ovf_set | (ovf_q & ~bus.clear_err);
      unf_q <= unf_set | (unf_q & ~bus.clear_err);
      if (do_write) begin
        mem[wr_idx] <= bus.push_addr;
      end
    end
  end

  assign bus.top_addr  = is_empty ? '0 : mem[sp_m1[DEPTH_LOG2-1:0]];
  assign bus.sp        = sp_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed CALL/RET scenarios then random traffic,
// compared against a queue-based model of a bounded stack with sticky error flags.
module tb_call_stack;
  localparam int ADDR_W     = 8;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk;
  logic rst_n;

  call_stack_if #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  call_stack #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] model_stack [$];
  bit model_ovf;
  bit model_unf;

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every output against the model's view of the stack.
  task automatic checkOutput(input string tag);
    int n;
    logic [ADDR_W-1:0] exp_top;
    n = model_stack.size();
    exp_top = (n == 0) ? '0 : model_stack[n-1];
    compare({tag, ".top_addr"},  32'(bus.top_addr),  32'(exp_top));
    compare({tag, ".sp"},        32'(bus.sp),        32'(n));
    compare({tag, ".empty"},     32'(bus.empty),     32'(n == 0));
    compare({tag, ".full"},      32'(bus.full),      32'(n == DEPTH));
    compare({tag, ".overflow"},  32'(bus.overflow),  32'(model_ovf));
    compare({tag, ".underflow"}, 32'(bus.underflow), 32'(model_unf));
  endtask

  task automatic modelStep(input bit p, input bit q, input logic [ADDR_W-1:0] a, input bit clr);
    bit new_ovf;
    bit new_unf;
    new_ovf = 1'b0;
    new_unf = 1'b0;
    if (p && q) begin
      if (model_stack.size() == 0) model_stack.push_back(a);
      else model_stack[model_stack.size()-1] = a;
    end else if (p) begin
      if (model_stack.size() == DEPTH) new_ovf = 1'b1;
      else model_stack.push_back(a);
    end else if (q) begin
      if (model_stack.size() == 0) new_unf = 1'b1;
      else void'(model_stack.pop_back());
    end
    if (clr) begin
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end
    if (new_ovf) model_ovf = 1'b1;
    if (new_unf) model_unf = 1'b1;
  endtask

  task automatic applyStimulus(input bit p, input bit q, input logic [ADDR_W-1:0] a, input bit clr);
    @(negedge clk);
    bus.push      = p;
    bus.pop       = q;
    bus.push_addr = a;
    bus.clear_err = clr;
    @(posedge clk);
    modelStep(p, q, a, clr);
    #1;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.clear_err = 1'b0;
    bus.push_addr = $urandom;
    checkOutput("step");
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    model_stack.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    #1;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.push_addr = '0;
    bus.clear_err = 1'b0;
    model_ovf = 1'b0;
    model_unf = 1'b0;
    #2;
    checkOutput("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Three calls then a return.
    applyStimulus(1, 0, 8'h10, 0);
    applyStimulus(1, 0, 8'h20, 0);
    applyStimulus(1, 0, 8'h30, 0);
    compare("t1.top", 32'(bus.top_addr), 32'h30);
    compare("t1.sp", 32'(bus.sp), 32'd3);
    applyStimulus(0, 1, 8'h00, 0);
    compare("t1.pop_top", 32'(bus.top_addr), 32'h20);

    // Fill, overflow, then tail call at full.
    doReset();
    for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 8'(i), 0);
    compare("t2.full", 32'(bus.full), 32'd1);
    applyStimulus(1, 0, 8'hFF, 0);
    compare("t2.ovf_top", 32'(bus.top_addr), 32'h08);
    compare("t2.ovf", 32'(bus.overflow), 32'd1);
    applyStimulus(1, 1, 8'hAA, 0);
    compare("t2.tail_top", 32'(bus.top_addr), 32'hAA);
    compare("t2.tail_sp", 32'(bus.sp), 32'd8);

    // Underflow and clear priority.
    doReset();
    applyStimulus(0, 1, 8'h00, 0);
    compare("t3.unf", 32'(bus.underflow), 32'd1);
    applyStimulus(0, 1, 8'h00, 1);
    compare("t3.unf_set_wins", 32'(bus.underflow), 32'd1);
    applyStimulus(0, 0, 8'h00, 1);
    compare("t3.unf_cleared", 32'(bus.underflow), 32'd0);

    // Push+pop from empty acts as push.
    applyStimulus(1, 1, 8'h55, 0);
    compare("t4.top", 32'(bus.top_addr), 32'h55);
    applyStimulus(1, 1, 8'h66, 0);
    compare("t4.top2", 32'(bus.top_addr), 32'h66);
    compare("t4.sp", 32'(bus.sp), 32'd1);

    // Asynchronous reset mid-cycle with sp=5 and overflow set.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h00, 0);
    compare("t5.pre_sp", 32'(bus.sp), 32'd5);
    compare("t5.pre_ovf", 32'(bus.overflow), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_stack.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    #1;
    checkOutput("t5.async");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 8'h12, 0);
    compare("t5.after", 32'(bus.top_addr), 32'h12);

    // Call/return depth walk.
    doReset();
    applyStimulus(1, 0, 8'h40, 0);
    applyStimulus(1, 0, 8'h41, 0);
    applyStimulus(0, 1, 8'h00, 0);
    compare("t6.ret1", 32'(bus.top_addr), 32'h40);
    applyStimulus(1, 0, 8'h42, 0);
    applyStimulus(0, 1, 8'h00, 0);
    applyStimulus(0, 1, 8'h00, 0);
    compare("t6.empty", 32'(bus.empty), 32'd1);

    // Random traffic with occasional clears and resets.
    doReset();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        doReset();
      end else begin
        applyStimulus(r < 50, (r >= 35) && (r < 85), 8'($urandom), ($urandom_range(0, 15) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware return-address stack for the Harvard CPU, clocked storage paired with the stack-pointer logic.
- Holds up to DEPTH program-counter values.
- Control unit asserts push on CALL (with the return PC) and pop on RET, and reads top_addr as the return target.
- Tracks occupancy and flags overflow/underflow for the debug/status path.

Parameters:
ADDR_W, 8, width of stored program-counter value
DEPTH_LOG2, 3, log2 of entry count (DEPTH = 8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
push  input  1  store push_addr on top of stack this cycle
pop  input  1  remove top entry this cycle
push_addr  input  ADDR_W  return address to store
clear_err  input  1  synchronous clear of sticky error flags
top_addr  output  ADDR_W  current top entry (combinational from storage); 0 when empty
sp  output  DEPTH_LOG2+1  current entry count, 0..DEPTH
empty  output  1  sp == 0
full  output  1  sp == DEPTH
overflow  output  1  sticky: push attempted while full (without pop)
underflow  output  1  sticky: pop attempted while empty (without push)

Behaviour:
- Reset (rst_n low, asynchronous): sp=0, overflow=0, underflow=0. Storage array is not reset. Resulting outputs: top_addr=0, empty=1, full=0. Reset mid-operation aborts any push/pop in that cycle.
- Storage: DEPTH x ADDR_W register array, written on clk rising edge only.
- Addressing: entry i at index i; top entry at index sp-1. top_addr = mem[sp-1] when sp>0, else 0. No added latency: the value pushed in cycle N appears on top_addr in cycle N+1.
- Per-cycle actions (evaluated on rising edge, rst_n high):
  - push only, not full: mem[sp] <= push_addr; sp <= sp+1.
  - push only, full: no write, sp unchanged; overflow <= 1.
  - pop only, not empty: sp <= sp-1; entry contents left in place.
  - pop only, empty: sp unchanged; underflow <= 1.
  - push and pop, sp>0: replace top, mem[sp-1] <= push_addr; sp unchanged; no flag (tail-call case, legal at full).
  - push and pop, empty: treated as push only; mem[0] <= push_addr; sp <= 1; no underflow.
  - neither: hold.
- Pop read timing: the RET-cycle consumer samples top_addr before the edge, so the popped value is the pre-edge top_addr.
- Error flags:
  - Sticky until clear_err or reset.
  - If clear_err and a new error event occur in the same cycle, the set wins (flag reads 1 next cycle).
  - clear_err alone clears both flags next cycle.
- Arithmetic: sp width DEPTH_LOG2+1, so DEPTH is representable. sp never wraps; the saturation at 0 and DEPTH is enforced by the rules above.
- empty/full are combinational decodes of sp.
- Undefined inputs: push_addr is ignored when push=0.

Test Plan:
1. Reset then 3 pushes of 0x10, 0x20, 0x30 -> sp=3, top_addr=0x30, empty=0. Pop -> next cycle sp=2, top_addr=0x20.
2. 8 pushes 0x01..0x08 -> full=1, sp=8, top_addr=0x08. 9th push of 0xFF -> sp=8, top_addr=0x08, overflow=1. Then push+pop of 0xAA -> sp=8, top_addr=0xAA, overflow stays 1.
3. Pop from empty after reset -> sp=0, top_addr=0, underflow=1. clear_err together with another empty pop -> underflow=1. clear_err alone -> underflow=0.
4. From empty, push+pop of 0x55 -> sp=1, top_addr=0x55, underflow=0. Push+pop of 0x66 -> sp=1, top_addr=0x66.
5. With sp=5 and overflow=1, assert rst_n low mid-cycle (asynchronous) -> immediately sp=0, empty=1, top_addr=0, overflow=0. After release, a push of 0x12 -> sp=1, top_addr=0x12.
6. Interleave call/return depth walk: push 0x40, push 0x41, pop, push 0x42, pop, pop -> top_addr sequence 0x40, 0x41, 0x40, 0x42, 0x40, 0 (empty=1); no flags set.
